// File: rtl/adc_src_arbiter_if.sv
// adc_src_arbiter_if
//   Bundles the sample-source side, the downstream dispatch handshake and the
//   overflow readout of adc_src_arbiter.
//   slave  : arbiter side (takes samples/ready/clear, drives word + overflow)
//   master : environment side (drives samples/ready/clear, observes outputs)
interface adc_src_arbiter_if #(
    parameter int N_SRC  = 8,
    parameter int W_SRC  = 5,
    parameter int W_DATA = 18,
    parameter int W_OVF  = 16
);
    logic [N_SRC-1:0]        dv_in;
    logic [N_SRC*W_DATA-1:0] data_in;
    logic                    rdy_in;
    logic                    ovf_clr_in;
    logic                    dv_out;
    logic [W_SRC-1:0]        src_out;
    logic [W_DATA-1:0]       data_out;
    logic [N_SRC-1:0]        ovf_flag_out;
    logic [W_OVF-1:0]        ovf_cnt_out;

    modport slave (
        input  dv_in, data_in, rdy_in, ovf_clr_in,
        output dv_out, src_out, data_out, ovf_flag_out, ovf_cnt_out
    );

    modport master (
        output dv_in, data_in, rdy_in, ovf_clr_in,
        input  dv_out, src_out, data_out, ovf_flag_out, ovf_cnt_out
    );
endinterface

// File: rtl/adc_src_arbiter.sv
// adc_src_arbiter
//   Merges N_SRC ADC sample streams into one registered word stream for the
//   dispatch input buffer. Each source owns a one-word holding slot; a
//   round-robin arbiter issues at most one word per cycle while rdy_in is high.
//   A new sample into a still-pending slot replaces the old one (newest wins)
//   and is recorded in a sticky per-source flag and a saturating counter.
//   Ports:
//     clk_in, rst_in : clock, async active-high reset
//     bus (slave)    : dv_in/data_in per-source samples, rdy_in, ovf_clr_in,
//                      dv_out/src_out/data_out word, ovf_flag_out, ovf_cnt_out

// Per-source holding slot. A grant and a capture in the same cycle hand the old
// word downstream and keep the slot pending with the new one.
module adc_src_slot #(
    parameter int W_DATA = 18
) (
    input  logic              clk_in,
    input  logic              rst_in,
    input  logic              dv,
    input  logic [W_DATA-1:0] data,
    input  logic              gnt,
    output logic              pend,
    output logic [W_DATA-1:0] hold,
    output logic              ovr
);
    assign ovr = dv & pend & ~gnt;

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            pend <= 1'b0;
            hold <= '0;
        end else if (dv) begin
            pend <= 1'b1;
            hold <= data;
        end else if (gnt) begin
            pend <= 1'b0;
        end
    end
endmodule

module adc_src_arbiter #(
    parameter int N_SRC  = 8,
    parameter int W_SRC  = 5,
    parameter int W_DATA = 18,
    parameter int W_OVF  = 16
) (
    input  logic               clk_in,
    input  logic               rst_in,
    adc_src_arbiter_if.slave   bus
);
    logic [N_SRC-1:0]             pend, ovr, gnt_oh, rot_pend, gnt_rot;
    logic [N_SRC-1:0][W_DATA-1:0] hold;
    logic [2*N_SRC-1:0]           gnt2;
    logic [W_SRC-1:0]             rr_ptr, gnt_idx;
    logic [W_DATA-1:0]            gnt_data;
    logic                         found, gnt_any;
    logic [W_SRC:0]               n_ovr;
    logic [W_OVF:0]               cnt_sum;

    logic                         dv_q;
    logic [W_SRC-1:0]             src_q;
    logic [W_DATA-1:0]            data_q;
    logic [N_SRC-1:0]             flag_q;
    logic [W_OVF-1:0]             cnt_q;

    genvar k;
    generate
        for (k = 0; k < N_SRC; k++) begin : g_slot
            adc_src_slot #(.W_DATA(W_DATA)) u_slot (
                .clk_in (clk_in),
                .rst_in (rst_in),
                .dv     (bus.dv_in[k]),
                .data   (bus.data_in[k*W_DATA +: W_DATA]),
                .gnt    (gnt_oh[k]),
                .pend   (pend[k]),
                .hold   (hold[k]),
                .ovr    (ovr[k])
            );
        end
    endgenerate

    // Round robin: rotate pend so rr_ptr sits at bit 0, pick the lowest set
    // bit, then rotate the one-hot back to absolute source positions.
    always_comb begin
        rot_pend = N_SRC'({pend, pend} >> rr_ptr);
        gnt_rot  = '0;
        found    = 1'b0;
        for (int o = 0; o < N_SRC; o++) begin
            if (!found && rot_pend[o]) begin
                gnt_rot[o] = 1'b1;
                found      = 1'b1;
            end
        end
        gnt_any = bus.rdy_in & found;
        gnt2    = {{N_SRC{1'b0}}, gnt_rot} << rr_ptr;
        gnt_oh  = gnt_any ? (gnt2[N_SRC-1:0] | gnt2[2*N_SRC-1:N_SRC]) : '0;

        gnt_idx  = '0;
        gnt_data = '0;
        n_ovr    = '0;
        for (int i = 0; i < N_SRC; i++) begin
            if (gnt_oh[i]) begin
                gnt_idx  = gnt_idx | W_SRC'(i);
                gnt_data = gnt_data | hold[i];
            end
            n_ovr = n_ovr + (W_SRC+1)'(ovr[i]);
        end

        // Clear discards history but keeps this cycle's events.
        cnt_sum = {1'b0, (bus.ovf_clr_in ? {W_OVF{1'b0}} : cnt_q)} + (W_OVF+1)'(n_ovr);
    end

    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            rr_ptr <= '0;
            dv_q   <= 1'b0;
            src_q  <= '0;
            data_q <= '0;
            flag_q <= '0;
            cnt_q  <= '0;
        end else begin
            dv_q <= gnt_any;
            if (gnt_any) begin
                src_q  <= gnt_idx;
                data_q <= gnt_data;
                rr_ptr <= (gnt_idx == W_SRC'(N_SRC-1)) ? '0 : gnt_idx + W_SRC'(1);
            end
            flag_q <= bus.ovf_clr_in ? ovr : (flag_q | ovr);
            cnt_q  <= cnt_sum[W_OVF] ? {W_OVF{1'b1}} : cnt_sum[W_OVF-1:0];
        end
    end

    assign bus.dv_out       = dv_q;
    assign bus.src_out      = src_q;
    assign bus.data_out     = data_q;
    assign bus.ovf_flag_out = flag_q;
    assign bus.ovf_cnt_out  = cnt_q;
endmodule

// File: tb/tb_adc_src_arbiter.sv
// tb_adc_src_arbiter
//   Directed stimulus pushes expected {src, data} words into a scoreboard
//   queue; an independent monitor pops and compares on every dv_out. Cycle
//   timing and overflow readout are checked directly by the stimulus thread.
module tb_adc_src_arbiter;
    localparam int N_SRC  = 8;
    localparam int W_SRC  = 5;
    localparam int W_DATA = 18;
    localparam int W_OVF  = 16;

    typedef struct packed {
        logic [W_SRC-1:0]  src;
        logic [W_DATA-1:0] data;
    } word_t;

    logic clk_in = 1'b0;
    logic rst_in = 1'b1;
    int   checks = 0;
    int   errors = 0;
    word_t exp_q[$];

    adc_src_arbiter_if #(.N_SRC(N_SRC), .W_SRC(W_SRC), .W_DATA(W_DATA), .W_OVF(W_OVF)) bus ();

    adc_src_arbiter #(.N_SRC(N_SRC), .W_SRC(W_SRC), .W_DATA(W_DATA), .W_OVF(W_OVF)) dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    always #5 clk_in = ~clk_in;

    task automatic chk(input string name, input longint act, input longint req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Advance to just after the next rising edge (inputs change here).
    task automatic cyc(input int n = 1);
        repeat (n) begin
            @(posedge clk_in);
            #1;
        end
    endtask

    task automatic send(input int k, input logic [W_DATA-1:0] d);
        bus.dv_in[k] = 1'b1;
        bus.data_in[k*W_DATA +: W_DATA] = d;
    endtask

    task automatic push(input int s, input logic [W_DATA-1:0] d);
        word_t w;
        w.src  = W_SRC'(s);
        w.data = d;
        exp_q.push_back(w);
    endtask

    // Monitor: every issued word must match the head of the scoreboard.
    always @(negedge clk_in) begin
        if (!rst_in && bus.dv_out) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_word", {bus.src_out, bus.data_out}, 0);
            end else begin
                word_t w;
                w = exp_q.pop_front();
                chk("word_src", bus.src_out, w.src);
                chk("word_data", bus.data_out, w.data);
            end
        end
    end

    initial begin
        logic [W_OVF-1:0] cnt_before;
        int dv_seen;
        bus.dv_in      = '0;
        bus.data_in    = '0;
        bus.rdy_in     = 1'b0;
        bus.ovf_clr_in = 1'b0;

        // Power-on reset values.
        #12;
        chk("rst_dv", bus.dv_out, 0);
        chk("rst_cnt", bus.ovf_cnt_out, 0);
        cyc(2);
        rst_in = 1'b0;
        cyc();

        // Burst: all sources at once, rr_ptr starts at 0.
        bus.rdy_in = 1'b1;
        for (int k = 0; k < N_SRC; k++) begin
            send(k, W_DATA'(k + 1));
            push(k, W_DATA'(k + 1));
        end
        cyc();
        bus.dv_in = '0;
        cyc(10);
        chk("burst_cnt", bus.ovf_cnt_out, 0);
        chk("burst_drained", exp_q.size(), 0);

        // Single word: visible exactly two cycles after the pulse.
        send(2, 18'h00123);
        push(2, 18'h00123);
        cyc();
        bus.dv_in = '0;
        cyc();
        chk("single_dv_t2", bus.dv_out, 1);
        chk("single_src_t2", bus.src_out, 2);
        cyc();
        chk("single_dv_t3", bus.dv_out, 0);

        // Round robin: last grant is 5, then 1 and 6 together -> 6 first.
        send(5, 18'h5);
        push(5, 18'h5);
        cyc();
        bus.dv_in = '0;
        cyc(3);
        send(1, 18'h11);
        send(6, 18'h66);
        push(6, 18'h66);
        push(1, 18'h11);
        cyc();
        bus.dv_in = '0;
        cyc(4);
        chk("rr_drained", exp_q.size(), 0);

        // Overwrite under backpressure, then a single word and a clear.
        bus.rdy_in = 1'b0;
        send(3, 18'h1);
        cyc();
        bus.dv_in = '0;
        cyc();
        send(3, 18'h2);
        push(3, 18'h2);
        cyc();
        bus.dv_in = '0;
        chk("ovf_dv_held_low", bus.dv_out, 0);
        cyc();
        chk("ovf_flag3", bus.ovf_flag_out, 8'h08);
        chk("ovf_cnt1", bus.ovf_cnt_out, 1);
        bus.rdy_in = 1'b1;
        chk("ovf_no_word_after_rdy0", bus.dv_out, 0);
        cyc(4);
        chk("ovf_drained", exp_q.size(), 0);
        bus.ovf_clr_in = 1'b1;
        cyc();
        bus.ovf_clr_in = 1'b0;
        chk("clr_flag", bus.ovf_flag_out, 0);
        chk("clr_cnt", bus.ovf_cnt_out, 0);

        // Grant/capture collision on source 0.
        cnt_before = bus.ovf_cnt_out;
        bus.rdy_in = 1'b0;
        send(0, 18'hA);
        push(0, 18'hA);
        cyc();
        bus.rdy_in = 1'b1;
        send(0, 18'hB);
        push(0, 18'hB);
        cyc();
        bus.dv_in = '0;
        cyc(4);
        chk("coll_cnt", bus.ovf_cnt_out, cnt_before);
        chk("coll_flag", bus.ovf_flag_out, 0);
        chk("coll_drained", exp_q.size(), 0);

        // Async reset mid-cycle with pending words and overflow state.
        bus.rdy_in = 1'b0;
        send(1, 18'h3FFFF);
        send(4, 18'h4);
        cyc();
        bus.dv_in = '0;
        send(1, 18'h2AAAA);
        cyc();
        bus.dv_in = '0;
        chk("pre_rst_cnt", bus.ovf_cnt_out, 1);
        #2;
        rst_in = 1'b1;
        #1;
        chk("arst_dv", bus.dv_out, 0);
        chk("arst_src", bus.src_out, 0);
        chk("arst_data", bus.data_out, 0);
        chk("arst_flag", bus.ovf_flag_out, 0);
        chk("arst_cnt", bus.ovf_cnt_out, 0);
        cyc(2);
        rst_in = 1'b0;
        bus.rdy_in = 1'b1;
        dv_seen = 0;
        repeat (20) begin
            @(negedge clk_in);
            if (bus.dv_out) dv_seen++;
        end
        chk("post_rst_quiet", dv_seen, 0);
        chk("final_drained", exp_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/adc_src_arbiter.md
# adc_src_arbiter

Merges the per-channel ADC sample streams into the single `dv_in/src_in/data_in` stream consumed by the instruction dispatch input buffer. Each source has a one-word holding register. A round-robin arbiter presents at most one word per cycle downstream and honours a ready signal from the dispatch buffer. Newest-sample-wins overwrite keeps PID inputs fresh under backpressure; dropped words are counted for host readout.

## Interface
- `N_SRC`, 8, number of sample sources; must satisfy `N_SRC <= 2**W_SRC`
- `W_SRC`, 5, width of the source id
- `W_DATA`, 18, sample width
- `W_OVF`, 16, overflow counter width
- `clk_in`  in  1  system clock; all state updates on the rising edge
- `rst_in`  in  1  reset, asynchronous, active-high
- `dv_in`  in  N_SRC  per-source data valid, one-cycle pulse per sample
- `data_in`  in  N_SRC*W_DATA  per-source sample; source k occupies bits [k*W_DATA +: W_DATA]
- `rdy_in`  in  1  downstream buffer can accept a word this cycle
- `ovf_clr_in`  in  1  clear overflow flags and counter
- `dv_out`  out  1  registered output word valid
- `src_out`  out  W_SRC  registered source id of the output word
- `data_out`  out  W_DATA  registered output sample
- `ovf_flag_out`  out  N_SRC  sticky per-source overwrite flag
- `ovf_cnt_out`  out  W_OVF  saturating total overwrite count

## Operation
- State:
  - `pend[N_SRC]`
  - `hold[N_SRC]` (W_DATA each)
  - `rr_ptr` (0..N_SRC-1)
  - output registers
  - `ovf_flag`
  - `ovf_cnt`
- Grant: in a cycle with `rdy_in=1` and any `pend` set, grant `g` = first pending index searching `rr_ptr, rr_ptr+1, ..., N_SRC-1, 0, ..., rr_ptr-1`.
- On grant:
  - `dv_out<=1`, `src_out<=g`, `data_out<=hold[g]`
  - `pend[g]<=0`
  - `rr_ptr<=(g+1) mod N_SRC`
- No grant, or `rdy_in=0`:
  - `dv_out<=0`
  - `src_out` and `data_out` hold their last values
  - `rr_ptr` unchanged
- Capture when `dv_in[k]=1`:
  - `hold[k]<=data_in[k]`, `pend[k]<=1`.
  - If `pend[k]` was already set and k is not granted this cycle, this is an overwrite: the old word is lost, `ovf_flag[k]<=1`, and it counts toward `ovf_cnt`.
- `dv_in[k]` in the same cycle as a grant of k:
  - the old held word goes out and the new word is captured
  - `pend[k]` stays 1
  - not an overwrite
- `ovf_cnt` increases by the number of overwrites in the cycle (0..N_SRC) and saturates at `2**W_OVF-1`.
- `ovf_clr_in=1`: flags and counter become that cycle's overwrite events only (previous state discarded). With no events in the cycle, both clear to 0.
- Reset, asynchronous:
  - `pend`, `rr_ptr`, `dv_out`, `src_out`, `data_out`, `ovf_flag_out`, `ovf_cnt_out` all go to 0 immediately.
  - Held words are discarded.
  - Deassertion takes effect at the next clock edge; the first capture is possible in that cycle.

## Timing
- Latency: sample with `dv_in[k]` high in cycle t is captured at the end of t, is grant-eligible in t+1, and appears with `dv_out=1` in t+2 (minimum).
- Throughput: one word per cycle while `rdy_in=1`.
- `rdy_in` is sampled in the grant cycle. A word is only issued if `rdy_in` was high in the preceding cycle; `dv_out` never asserts in the cycle after `rdy_in=0`.
- Fairness: with `rdy_in` held high, a pending source is granted within N_SRC cycles of becoming pending.
- `dv_out` is a single-cycle pulse per word; back-to-back pulses are allowed.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- **Reset.** Pulse `rst_in` mid-cycle with several `pend` set.
  - All outputs 0 without waiting for a clock edge.
  - After release with no `dv_in`: `dv_out` stays 0 for 20 cycles.
- **Single word.** `rdy_in=1`; `dv_in[2]` pulse with `data_in[2]=18'h00123` in cycle t.
  - Cycle t+2: `dv_out=1`, `src_out=2`, `data_out=18'h00123`.
  - Cycle t+3: `dv_out=0`.
- **Burst.** All 8 sources pulse together with `data=k+1`, `rdy_in=1`.
  - 8 consecutive `dv_out` cycles with `src_out` 0..7 and data 1..8.
  - `ovf_cnt_out=0`.
- **Round robin.** Last grant was src 5; sources 1 and 6 become pending together.
  - Src 6 is issued first, then src 1.
- **Overwrite and clear.** `rdy_in=0`; src 3 sends 18'h1, then 18'h2 two cycles later.
  - `ovf_flag_out[3]=1`, `ovf_cnt_out=1`.
  - Raise `rdy_in`: exactly one word is issued, `src_out=3`, `data_out=18'h2`.
  - Pulse `ovf_clr_in`: flag and count return to 0.
- **Grant/capture collision.** `rdy_in=1`; src 0 is pending with 18'hA and `dv_in[0]` carries 18'hB in the grant cycle.
  - 18'hA is issued, then 18'hB on the next grant of src 0.
  - `ovf_cnt_out` unchanged.
